// File: rtl/timer_counter_if.sv
// Device-bus port bundle for timer_counter: CPU-side word access plus the interrupt line.
interface timer_counter_if;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    modport master (output Addr, We, DIn, input DOut, IRQ);
    modport slave  (input Addr, We, DIn, output DOut, IRQ);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, one-shot or auto-reload,
// with an interrupt flag gated by the IM bit.
module timer_counter (
    input  logic            clk,
    input  logic            reset,
    timer_counter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  ctrl_reg;
    logic [31:0] preset_reg;
    logic [31:0] count_reg;
    logic        irq_flag_reg;

    logic enable, auto_reload, irq_mask;
    logic cpu_ctrl_wr, cpu_preset_wr;
    logic load_count, dec_count, set_irq, hw_clr_irq, hw_clr_en;
    logic unused_din_bits;

    assign enable      = ctrl_reg[0];
    assign auto_reload = (ctrl_reg[2:1] == 2'b01);
    assign irq_mask    = ctrl_reg[3];

    assign cpu_ctrl_wr   = bus.We && (bus.Addr == 2'd0);
    assign cpu_preset_wr = bus.We && (bus.Addr == 2'd1);
    assign unused_din_bits = &bus.DIn[31:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (enable) state_next = LOAD;
            LOAD: state_next = CNT;
            CNT: begin
                if (!enable)             state_next = IDLE;
                else if (count_reg == 0) state_next = INT;
            end
            INT:  state_next = auto_reload ? LOAD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_count = (state_reg == LOAD);
        dec_count  = (state_reg == CNT) && enable && (count_reg != 32'd0);
        set_irq    = (state_reg == CNT) && enable && (count_reg == 32'd0);
        hw_clr_irq = (state_reg == INT) && auto_reload;
        hw_clr_en  = (state_reg == INT) && !auto_reload;
    end

    // A CPU write always wins over the hardware-side updates on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_reg     <= 4'd0;
            preset_reg   <= 32'd0;
            count_reg    <= 32'd0;
            irq_flag_reg <= 1'b0;
        end else begin
            if (cpu_ctrl_wr)    ctrl_reg    <= bus.DIn[3:0];
            else if (hw_clr_en) ctrl_reg[0] <= 1'b0;

            if (cpu_preset_wr) preset_reg <= bus.DIn;

            if (load_count)     count_reg <= preset_reg;
            else if (dec_count) count_reg <= count_reg - 32'd1;

            if (cpu_ctrl_wr || cpu_preset_wr) irq_flag_reg <= 1'b0;
            else if (set_irq)                 irq_flag_reg <= 1'b1;
            else if (hw_clr_irq)              irq_flag_reg <= 1'b0;
        end
    end

    always_comb begin
        case (bus.Addr)
            2'd0:    bus.DOut = {28'd0, ctrl_reg};
            2'd1:    bus.DOut = preset_reg;
            2'd2:    bus.DOut = count_reg;
            default: bus.DOut = 32'd0;
        endcase
    end

    assign bus.IRQ = irq_flag_reg & irq_mask;
endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: vector table, hand-written corner sequences,
// and randomized traffic checked against a behavioural model.
module tb_timer_counter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #10 clk = ~clk;

    timer_counter_if bus ();
    timer_counter dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: activity tracked as independent "pending" flags.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset, m_count;
    bit          m_flag, m_loading, m_counting, m_fired;

    typedef struct {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;
    vec_t tbl [16];

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0;
        m_flag = 0; m_loading = 0; m_counting = 0; m_fired = 0;
    endtask

    task automatic model_edge(input logic we, input logic [1:0] a, input logic [31:0] d);
        logic        en, auto_mode;
        logic [3:0]  n_ctrl;
        logic [31:0] n_preset, n_count;
        bit          n_flag, n_load, n_cnt, n_fired;
        en = m_ctrl[0];
        auto_mode = (m_ctrl[2:1] == 2'b01);
        n_ctrl = m_ctrl; n_preset = m_preset; n_count = m_count; n_flag = m_flag;
        n_load = 0; n_cnt = 0; n_fired = 0;
        if (m_loading) begin
            n_count = m_preset;
            n_cnt = 1;
        end else if (m_counting) begin
            if (en) begin
                if (m_count != 0) begin
                    n_count = m_count - 1;
                    n_cnt = 1;
                end else begin
                    n_fired = 1;
                    n_flag = 1;
                end
            end
        end else if (m_fired) begin
            if (auto_mode) begin
                n_load = 1;
                n_flag = 0;
            end else begin
                n_ctrl[0] = 1'b0;
            end
        end else if (en) begin
            n_load = 1;
        end
        if (we && a == 2'd0) begin n_ctrl = d[3:0]; n_flag = 0; end
        if (we && a == 2'd1) begin n_preset = d;    n_flag = 0; end
        m_ctrl = n_ctrl; m_preset = n_preset; m_count = n_count; m_flag = n_flag;
        m_loading = n_load; m_counting = n_cnt; m_fired = n_fired;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] a, input logic [31:0] d);
        bus.We = we; bus.Addr = a; bus.DIn = d;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(bus.We, bus.Addr, bus.DIn);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        drive(1'b0, 2'd0, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Reset dropped between edges must clear everything combinationally.
    task automatic async_reset_check(input string name);
        #2 reset = 1'b0;
        model_reset();
        bus.We = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus.Addr = 2'(a);
            #1;
            check({name, "_dout"}, bus.DOut, 32'd0);
            check({name, "_irq"}, {31'd0, bus.IRQ}, 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int ar_cnt [6];
        ar_cnt = '{3, 2, 1, 0, 0, 0};
        tbl[0]  = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_000F, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 32'h0,         32'h0,         1'b0};
        tbl[2]  = '{1'b0, 2'd2, 32'h0,         32'h0,         1'b0};
        tbl[3]  = '{1'b0, 2'd2, 32'h0,         32'h0,         1'b0};
        tbl[4]  = '{1'b1, 2'd1, 32'h2,         32'h2,         1'b0};
        tbl[5]  = '{1'b1, 2'd2, 32'h1234,      32'h0,         1'b0};
        tbl[6]  = '{1'b1, 2'd3, 32'h5,         32'h0,         1'b0};
        tbl[7]  = '{1'b1, 2'd0, 32'h9,         32'h9,         1'b0};
        tbl[8]  = '{1'b0, 2'd2, 32'h0,         32'h0,         1'b0};
        tbl[9]  = '{1'b0, 2'd2, 32'h0,         32'h2,         1'b0};
        tbl[10] = '{1'b0, 2'd2, 32'h0,         32'h1,         1'b0};
        tbl[11] = '{1'b0, 2'd2, 32'h0,         32'h0,         1'b0};
        tbl[12] = '{1'b0, 2'd2, 32'h0,         32'h0,         1'b1};
        tbl[13] = '{1'b0, 2'd0, 32'h0,         32'h8,         1'b1};
        tbl[14] = '{1'b0, 2'd0, 32'h0,         32'h8,         1'b1};
        tbl[15] = '{1'b1, 2'd1, 32'h3,         32'h3,         1'b0};

        do_reset();
        for (int a = 0; a < 4; a++) begin
            bus.Addr = 2'(a);
            #1 check("reset_dout", bus.DOut, 32'd0);
        end
        check("reset_irq", {31'd0, bus.IRQ}, 32'd0);

        // Readback, ignored writes, short one-shot with held IRQ cleared by PRESET write.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].we, tbl[i].addr, tbl[i].din);
            tick();
            $display("vec %0d: we=%0d addr=%0d din=%h dout=%h irq=%0d", i, tbl[i].we,
                     tbl[i].addr, tbl[i].din, bus.DOut, bus.IRQ);
            check($sformatf("tbl%0d_dout", i), bus.DOut, tbl[i].exp_dout);
            check($sformatf("tbl%0d_irq", i), {31'd0, bus.IRQ}, {31'd0, tbl[i].exp_irq});
        end

        // Auto-reload, PRESET=3: one-cycle pulse every 6 cycles, COUNT reloads to 3.
        do_reset();
        drive(1'b1, 2'd1, 32'd3); tick();
        drive(1'b1, 2'd0, 32'hB); tick();
        $display("seq auto_reload: PRESET=3 CTRL=0xB");
        for (int c = 1; c <= 26; c++) begin
            drive(1'b0, 2'd2, 32'd0); tick();
            check($sformatf("ar_irq_c%0d", c), {31'd0, bus.IRQ}, {31'd0, (c >= 6 && c % 6 == 0)});
            if (c >= 2) check($sformatf("ar_cnt_c%0d", c), bus.DOut, 32'(ar_cnt[(c - 2) % 6]));
        end

        // CTRL write on the CNT->INT edge, then re-enable on the INT edge.
        do_reset();
        drive(1'b1, 2'd1, 32'd2); tick();
        drive(1'b1, 2'd0, 32'h9); tick();
        $display("seq collision: PRESET=2 CTRL=0x9");
        for (int c = 1; c <= 4; c++) begin drive(1'b0, 2'd2, 32'd0); tick(); end
        drive(1'b1, 2'd0, 32'hD); tick();
        check("col_irq", {31'd0, bus.IRQ}, 32'd0);
        check("col_ctrl", bus.DOut, 32'hD);
        drive(1'b1, 2'd0, 32'h9); tick();
        check("col_ctrl_kept", bus.DOut, 32'h9);
        check("col_irq2", {31'd0, bus.IRQ}, 32'd0);
        drive(1'b0, 2'd2, 32'd0); tick(); tick();
        check("col_reload", bus.DOut, 32'd2);

        // Pause at COUNT=7, hold, re-enable reloads, IM=0 completion keeps IRQ low.
        do_reset();
        drive(1'b1, 2'd1, 32'd20); tick();
        drive(1'b1, 2'd0, 32'h1); tick();
        $display("seq pause: PRESET=20 CTRL=0x1");
        for (int c = 1; c <= 14; c++) begin drive(1'b0, 2'd2, 32'd0); tick(); end
        drive(1'b1, 2'd0, 32'h0); tick();
        drive(1'b0, 2'd2, 32'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("pause_hold%0d", c), bus.DOut, 32'd7);
        end
        drive(1'b1, 2'd0, 32'h1); tick();
        drive(1'b0, 2'd2, 32'd0); tick(); tick();
        check("pause_reload", bus.DOut, 32'd20);
        for (int c = 3; c <= 25; c++) begin
            tick();
            check($sformatf("mask_irq_c%0d", c), {31'd0, bus.IRQ}, 32'd0);
            if (c == 22) check("mask_cnt_zero", bus.DOut, 32'd0);
        end
        drive(1'b0, 2'd0, 32'd0); tick();
        check("mask_en_cleared", bus.DOut, 32'd0);

        // PRESET=0 auto-reload: 3-cycle period.
        do_reset();
        drive(1'b1, 2'd0, 32'hB); tick();
        $display("seq preset0: CTRL=0xB");
        for (int c = 1; c <= 12; c++) begin
            drive(1'b0, 2'd2, 32'd0); tick();
            check($sformatf("p0_irq_c%0d", c), {31'd0, bus.IRQ}, {31'd0, (c % 3 == 0)});
        end

        // Reset mid-count aborts without an interrupt.
        do_reset();
        drive(1'b1, 2'd1, 32'd4); tick();
        drive(1'b1, 2'd0, 32'h9); tick();
        drive(1'b0, 2'd2, 32'd0); tick(); tick(); tick();
        $display("seq async_reset mid-count");
        async_reset_check("midreset");
        drive(1'b0, 2'd2, 32'd0);
        for (int c = 0; c < 12; c++) begin
            tick();
            check("midreset_irq", {31'd0, bus.IRQ}, 32'd0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0)      drive(1'b1, 2'd0, $urandom());
            else if (r == 1) drive(1'b1, 2'd1, 32'($urandom_range(0, 10)));
            else if (r == 2) drive(1'b1, 2'($urandom_range(2, 3)), $urandom());
            else             drive(1'b0, 2'($urandom_range(0, 3)), $urandom());
            if (bus.We)
                $display("rand %0d: write addr=%0d data=%h", c, bus.Addr, bus.DIn);
            tick();
            check($sformatf("rand%0d_dout_a%0d", c, bus.Addr), bus.DOut, m_read(bus.Addr));
            check($sformatf("rand%0d_irq", c), {31'd0, bus.IRQ}, {31'd0, m_flag & m_ctrl[3]});
            if ($urandom_range(0, 499) == 0) begin
                $display("rand %0d: async reset", c);
                async_reset_check("rand_reset");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
